// File: rtl/receiver.sv
// UART receive path for the 8N1 serial link driven by the matching transmitter.
// The input is oversampled at the system clock. Each frame is sampled at mid-bit
// and every good byte is announced with a single-cycle rx_valid pulse.
// Optional feature macro: RX_PARITY_EN adds an even-parity bit after the data
// bits and a parity_err output. Without it the link is plain 8N1.
`timescale 1ns/1ps

module receiver #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data,
  output logic                 rx_valid,
  output logic                 frame_err
`ifdef RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_IDX  = 3'(DATA_BITS - 1);

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [2:0]           idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 rx_meta;
  logic                 rx_s;
`ifdef RX_PARITY_EN
  logic                 par_bad;
`endif

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  // Frame recovery FSM with registered data and single-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift_reg  <= '0;
      data       <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
`ifdef RX_PARITY_EN
      parity_err <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
`ifdef RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
            idx   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == FULL_LAST) begin
            cnt            <= '0;
            shift_reg[idx] <= rx_s;
            if (idx == LAST_IDX) begin
`ifdef RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef RX_PARITY_EN
        PARITY: begin
          if (cnt == FULL_LAST) begin
            cnt     <= '0;
            par_bad <= (rx_s != (^shift_reg));
            state   <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (cnt == FULL_LAST) begin
            cnt <= '0;
            if (rx_s) begin
`ifdef RX_PARITY_EN
              if (par_bad) begin
                parity_err <= 1'b1;
              end else begin
                data     <= shift_reg;
                rx_valid <= 1'b1;
              end
`else
              data     <= shift_reg;
              rx_valid <= 1'b1;
`endif
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
